// File: rtl/sig_rom_arbiter_pkg.sv
// Shared constants for the sigmoid ROM arbiter: FSM encoding and default sizes.
package sig_arb_pkg;

  localparam int NUM_REQ_DEF   = 4;
  localparam int IN_WIDTH_DEF  = 5;
  localparam int OUT_WIDTH_DEF = 8;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_FETCH = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

endpackage

// File: rtl/sig_rom_arbiter_rom.sv
// Sigmoid lookup ROM: registered offset address, table of round(255/(1+exp(-x/4)))
// for signed 5-bit x in quarter units (-4.0 .. 3.75).
module Sig_ROM #(
  parameter int inWidth  = 5,
  parameter int outWidth = 8
) (
  input  logic                      clk,
  input  logic                      en,
  input  logic signed [inWidth-1:0] x,
  output logic [outWidth-1:0]       y
);

  localparam logic [7:0] TBL [32] = '{
    8'd5,   8'd6,   8'd7,   8'd10,  8'd12,  8'd15,  8'd19,  8'd24,
    8'd30,  8'd38,  8'd47,  8'd57,  8'd69,  8'd82,  8'd96,  8'd112,
    8'd128, 8'd143, 8'd159, 8'd173, 8'd186, 8'd198, 8'd208, 8'd217,
    8'd225, 8'd231, 8'd236, 8'd240, 8'd243, 8'd245, 8'd248, 8'd249
  };

  logic [inWidth-1:0] addr_q;

  // Adding 2^(inWidth-1) modulo 2^inWidth is just an MSB flip.
  always_ff @(posedge clk) begin
    if (en) addr_q <= {~x[inWidth-1], x[inWidth-2:0]};
  end

  assign y = outWidth'(TBL[addr_q]);

endmodule

// File: rtl/sig_rom_arbiter.sv
// Round-robin arbiter sharing one sigmoid ROM between NUM_REQ neurons,
// one lookup in flight at a time (accept, issue, fetch, respond).
module sig_rom_arbiter
  import sig_arb_pkg::*;
#(
  parameter int NUM_REQ   = NUM_REQ_DEF,
  parameter int IN_WIDTH  = IN_WIDTH_DEF,
  parameter int OUT_WIDTH = OUT_WIDTH_DEF,
  localparam int ID_W     = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*IN_WIDTH-1:0]   req_x,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          rsp_valid,
  output logic [ID_W-1:0]               rsp_id,
  output logic [OUT_WIDTH-1:0]          rsp_data,
  input  logic                          rsp_ready,
  output logic                          busy
);

  logic [1:0]                  state;
  logic [ID_W-1:0]             ptr;
  logic [ID_W-1:0]             win_id;
  logic [ID_W-1:0]             id_q;
  logic [NUM_REQ-1:0]          grant;
  logic                        any_req;
  int                          scan_idx;
  logic signed [IN_WIDTH-1:0]  win_x;
  logic signed [IN_WIDTH-1:0]  x_q;
  logic [OUT_WIDTH-1:0]        rom_data;

  // Scan from ptr upward with wrap; the first valid requester wins.
  always_comb begin
    grant    = '0;
    win_id   = '0;
    any_req  = 1'b0;
    scan_idx = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = int'(ptr) + k;
      if (scan_idx >= NUM_REQ) scan_idx = scan_idx - NUM_REQ;
      if (!any_req && req_valid[scan_idx]) begin
        any_req          = 1'b1;
        win_id           = ID_W'(scan_idx);
        grant[scan_idx]  = 1'b1;
      end
    end
  end

  assign win_x     = req_x[win_id*IN_WIDTH +: IN_WIDTH];
  assign req_ready = (state == ST_IDLE && rst_n) ? grant : '0;
  assign rsp_valid = (state == ST_RESP);
  assign busy      = (state != ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      ptr      <= '0;
      rsp_id   <= '0;
      rsp_data <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (any_req) begin
            state <= ST_ISSUE;
            ptr   <= (win_id == ID_W'(NUM_REQ-1)) ? '0 : win_id + 1'b1;
          end
        end
        ST_ISSUE: state <= ST_FETCH;
        ST_FETCH: begin
          state    <= ST_RESP;
          rsp_id   <= id_q;
          rsp_data <= rom_data;
        end
        default: begin
          if (rsp_ready) state <= ST_IDLE;
        end
      endcase
    end
  end

  // Accept boundary: operand and owner frozen for the whole transaction.
  always_ff @(posedge clk) begin
    if (state == ST_IDLE && any_req) begin
      x_q  <= win_x;
      id_q <= win_id;
    end
  end

  Sig_ROM #(
    .inWidth  (IN_WIDTH),
    .outWidth (OUT_WIDTH)
  ) u_rom (
    .clk (clk),
    .en  (state == ST_ISSUE),
    .x   (x_q),
    .y   (rom_data)
  );

endmodule

// File: doc/sig_rom_arbiter.md
SIG_ROM_ARBITER -- requirements
Module: sig_rom_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of requesting neurons (2..16).
REQ-002 SHALL have parameter IN_WIDTH, default 5: signed lookup operand width, matching the sigmoid ROM address width.
REQ-003 SHALL have parameter OUT_WIDTH, default 8: sigmoid result width.
REQ-004 SHALL have port `clk`, input, 1 bit: single clock; all state updates on the rising edge.
REQ-005 SHALL have port `rst_n`, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port `req_valid`, input, NUM_REQ bits: bit i high means requester i has an operand pending.
REQ-007 SHALL have port `req_x`, input, NUM_REQ*IN_WIDTH bits: requester i's signed operand in slice [i*IN_WIDTH +: IN_WIDTH].
REQ-008 SHALL have port `req_ready`, output, NUM_REQ bits: one-hot accept strobe; requester i is accepted on a cycle where req_valid[i] and req_ready[i] are both high.
REQ-009 SHALL have port `rsp_valid`, output, 1 bit: a result is presented.
REQ-010 SHALL have port `rsp_id`, output, clog2(NUM_REQ) bits: index of the requester owning the result.
REQ-011 SHALL have port `rsp_data`, output, OUT_WIDTH bits: sigmoid value.
REQ-012 SHALL have port `rsp_ready`, input, 1 bit: consumer accepts the result on a cycle where rsp_valid and rsp_ready are both high.
REQ-013 SHALL have port `busy`, output, 1 bit: high whenever the FSM is not in IDLE.

Function
REQ-014 SHALL implement FSM states IDLE, ISSUE, FETCH and RESP.
REQ-015 IDLE: when any req_valid bit is high, SHALL drive req_ready combinationally to the one-hot round-robin winner, register that requester's operand into x_q and its index into id_q, then go to ISSUE; otherwise SHALL hold req_ready at 0 and stay in IDLE.
REQ-016 ISSUE: SHALL present x_q to the ROM, which registers its offset address (x+2^(IN_WIDTH-1) mod 2^IN_WIDTH) at this edge, then go to FETCH.
REQ-017 FETCH: SHALL capture the ROM output into rsp_data and id_q into rsp_id, then go to RESP.
REQ-018 RESP: SHALL hold rsp_valid=1 with rsp_data and rsp_id stable until rsp_ready=1, then go to IDLE on that edge.
REQ-019 Latency: rsp_valid SHALL rise exactly 3 cycles after the accept edge; with rsp_ready held at 1, a new accept SHALL be possible every 4 cycles.
REQ-020 req_ready SHALL be 0 in every state except IDLE; at most one bit SHALL be high at any time.
REQ-021 Round-robin: search SHALL begin at pointer ptr and wrap from NUM_REQ-1 to 0; after each grant, ptr SHALL become winner+1 (mod NUM_REQ).
REQ-022 With a single requester active, that requester SHALL be granted regardless of ptr.
REQ-023 A change in req_valid or req_x while busy SHALL have no effect on the transaction in flight.
REQ-024 Operand -2^(IN_WIDTH-1) SHALL map to ROM index 0, operand 0 to index 2^(IN_WIDTH-1), and operand 2^(IN_WIDTH-1)-1 to the last index.

Reset
REQ-025 Asserting rst_n low SHALL immediately force state=IDLE, ptr=0, req_ready=0, rsp_valid=0, rsp_id=0, rsp_data=0 and busy=0.
REQ-026 A reset in any state, including mid-RESP, SHALL discard the in-flight result with no response emitted.
REQ-027 The first grant after reset deassertion SHALL search starting from requester 0.

Structure
REQ-028 The package sig_arb_pkg SHALL hold the FSM state encoding and the default NUM_REQ, IN_WIDTH and OUT_WIDTH constants.
REQ-029 The block SHALL instantiate exactly one existing Sig_ROM sub-module (inWidth=IN_WIDTH), driven from x_q.
REQ-030 The round-robin selector SHALL be local logic and SHALL NOT be a separate module.

Verification
REQ-031 Single request: req_valid=4'b0001, x=5'sd0, rsp_ready=1 -> req_ready=4'b0001 for one cycle; 3 cycles later rsp_valid=1, rsp_id=0, rsp_data=ROM[16].
REQ-032 Fairness: all four requesters valid continuously after reset -> grant order 0,1,2,3,0, one grant every 4 cycles.
REQ-033 Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rsp_id and rsp_data stable, req_ready=0, busy=1; release -> IDLE the next cycle.
REQ-034 Boundaries: x=-16 -> ROM[0]; x=15 -> ROM[31]; x=-1 -> ROM[15].
REQ-035 Reset mid-FETCH: rst_n pulsed low -> all outputs 0 immediately, no response; the next request is granted from requester 0.
REQ-036 Operand change: req_x[1] altered in ISSUE -> response carries the value captured at accept.
